// File: rtl/rom_load_arbiter_pkg.sv
// Shared types and constants for the ROM load arbiter: FSM encoding, FIFO entry layout
// and the cartridge header size.
package rom_load_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE    = 2'd0;
    localparam state_t ISSUE_W = 2'd1;
    localparam state_t ISSUE_R = 2'd2;
    localparam state_t WAIT    = 2'd3;

    localparam int unsigned HEADER_BYTES = 512;

    typedef struct packed {
        logic [20:0] addr;
        logic [15:0] data;
    } rom_word_t;

endpackage

// File: rtl/rom_load_arbiter_if.sv
// ROM port between the load arbiter (master) and the SDRAM controller (slave),
// using a toggle request/acknowledge handshake.
interface rom_load_arbiter_if;

    logic [20:0] rom_addr;
    logic [15:0] rom_din;
    logic        rom_we;
    logic        rom_req;
    logic        rom_req_ack;
    logic [15:0] rom_dout;

    modport master (
        output rom_addr,
        output rom_din,
        output rom_we,
        output rom_req,
        input  rom_req_ack,
        input  rom_dout
    );

    modport slave (
        input  rom_addr,
        input  rom_din,
        input  rom_we,
        input  rom_req,
        output rom_req_ack,
        output rom_dout
    );

endinterface

// File: rtl/rom_load_arbiter_word_fifo.sv
// Synchronous word FIFO with occupancy count. Pushes while full and pops while empty are
// ignored; the caller is expected to flag the former.
module rom_word_fifo
    import rom_load_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  rom_word_t                wdata,
    input  logic                     pop,
    output rom_word_t                rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    rom_word_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q;
    logic [AW-1:0]     rd_ptr_q;
    logic [AW:0]       count_q;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem_q[rd_ptr_q];
    assign count   = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW + 1)'(1);
                2'b01:   count_q <= count_q - (AW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/rom_load_arbiter.sv
// Packs the ioctl download byte stream into SDRAM ROM words and serves CPU ROM reads over the
// same toggle-handshake port. Optional ROM_HEADER_SKIP_EN drops a 512-byte file header.
module rom_load_arbiter
    import rom_load_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  PAD_BYTE   = 8'hFF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ioctl_download,
    input  logic                 ioctl_wr,
    input  logic [21:0]          ioctl_addr,
    input  logic [7:0]           ioctl_dout,
    output logic                 ioctl_wait,
    input  logic                 cpu_rd,
    input  logic [20:0]          cpu_addr,
    output logic [15:0]          cpu_dout,
    output logic                 cpu_rdy,
    rom_load_arbiter_if.master   rom,
    output logic [21:0]          rom_size
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    // Download tracking
    logic        dl_q;
    logic        dl_rise;
    logic        dl_fall;
    logic [7:0]  low_q,       low_d;
    logic        low_valid_q, low_valid_d;
    logic [20:0] low_waddr_q, low_waddr_d;
    logic [21:0] end_q,       end_d;
    logic [21:0] size_q,      size_d;
    logic        overflow_q;

    logic        byte_keep;
    logic [21:0] eff_addr;
    logic        wr_ok;

    // FIFO
    logic        fifo_push;
    rom_word_t   fifo_wdata;
    logic        fifo_pop;
    rom_word_t   fifo_head;
    logic [CW-1:0] fifo_count;
    logic        fifo_full;
    logic        fifo_empty;

    // SDRAM side
    state_t      state_q,    state_d;
    logic [20:0] addr_q,     addr_d;
    logic [15:0] din_q,      din_d;
    logic        we_q,       we_d;
    logic        req_q,      req_d;
    logic [15:0] cpu_dout_q, cpu_dout_d;
    logic        rdy_q,      rdy_d;
    logic        rd_pend_q,  rd_pend_d;
    logic [20:0] rd_addr_q,  rd_addr_d;

    assign dl_rise = ioctl_download && !dl_q;
    assign dl_fall = !ioctl_download && dl_q;

`ifdef ROM_HEADER_SKIP_EN
    // Header bytes are discarded and the payload rebased to address 0.
    assign byte_keep = (ioctl_addr >= 22'(HEADER_BYTES));
    assign eff_addr  = ioctl_addr - 22'(HEADER_BYTES);
`else
    assign byte_keep = 1'b1;
    assign eff_addr  = ioctl_addr;
`endif

    assign wr_ok = ioctl_download && ioctl_wr && byte_keep;

    always_comb begin
        low_d       = low_q;
        low_valid_d = low_valid_q;
        low_waddr_d = low_waddr_q;
        end_d       = end_q;
        size_d      = size_q;
        fifo_push   = 1'b0;
        fifo_wdata  = '0;

        if (dl_rise) begin
            low_valid_d = 1'b0;
            end_d       = '0;
        end

        if (wr_ok) begin
            if (!eff_addr[0]) begin
                low_d       = ioctl_dout;
                low_valid_d = 1'b1;
                low_waddr_d = eff_addr[21:1];
            end else begin
                fifo_push       = 1'b1;
                fifo_wdata.addr = eff_addr[21:1];
                // Only pair with a latched low byte belonging to the same word.
                if (low_valid_q && !dl_rise && (low_waddr_q == eff_addr[21:1])) begin
                    fifo_wdata.data = {ioctl_dout, low_q};
                end else begin
                    fifo_wdata.data = {ioctl_dout, PAD_BYTE};
                end
                low_valid_d = 1'b0;
            end
            if ((eff_addr + 22'd1) > end_d) end_d = eff_addr + 22'd1;
        end

        if (dl_fall) begin
            if (low_valid_q) begin
                fifo_push       = 1'b1;
                fifo_wdata.addr = low_waddr_q;
                fifo_wdata.data = {PAD_BYTE, low_q};
            end
            low_valid_d = 1'b0;
            size_d      = end_q;
        end
    end

    rom_word_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata (fifo_wdata),
        .pop   (fifo_pop),
        .rdata (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Leaves room for one more in-flight byte pair after the downloader sees the stall.
    assign ioctl_wait = (fifo_count >= CW'(FIFO_DEPTH - 1));

    always_comb begin
        state_d    = state_q;
        fifo_pop   = 1'b0;
        addr_d     = addr_q;
        din_d      = din_q;
        we_d       = we_q;
        req_d      = req_q;
        cpu_dout_d = cpu_dout_q;
        rdy_d      = 1'b0;
        rd_pend_d  = rd_pend_q;
        rd_addr_d  = rd_addr_q;

        if (cpu_rd && !rd_pend_q) begin
            rd_pend_d = 1'b1;
            rd_addr_d = cpu_addr;
        end

        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    state_d = ISSUE_W;
                end else if (rd_pend_q && !ioctl_download) begin
                    state_d = ISSUE_R;
                end
            end
            ISSUE_W: begin
                fifo_pop = 1'b1;
                addr_d   = fifo_head.addr;
                din_d    = fifo_head.data;
                we_d     = 1'b1;
                req_d    = ~req_q;
                state_d  = WAIT;
            end
            ISSUE_R: begin
                addr_d  = rd_addr_q;
                we_d    = 1'b0;
                req_d   = ~req_q;
                state_d = WAIT;
            end
            WAIT: begin
                if (rom.rom_req_ack == req_q) begin
                    if (!we_q) begin
                        cpu_dout_d = rom.rom_dout;
                        rdy_d      = 1'b1;
                        rd_pend_d  = 1'b0;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dl_q        <= 1'b0;
            low_q       <= '0;
            low_valid_q <= 1'b0;
            low_waddr_q <= '0;
            end_q       <= '0;
            size_q      <= '0;
            overflow_q  <= 1'b0;
            state_q     <= IDLE;
            addr_q      <= '0;
            din_q       <= '0;
            we_q        <= 1'b0;
            req_q       <= 1'b0;
            cpu_dout_q  <= '0;
            rdy_q       <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_addr_q   <= '0;
        end else begin
            dl_q        <= ioctl_download;
            low_q       <= low_d;
            low_valid_q <= low_valid_d;
            low_waddr_q <= low_waddr_d;
            end_q       <= end_d;
            size_q      <= size_d;
            overflow_q  <= overflow_q | (fifo_push & fifo_full);
            state_q     <= state_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            we_q        <= we_d;
            req_q       <= req_d;
            cpu_dout_q  <= cpu_dout_d;
            rdy_q       <= rdy_d;
            rd_pend_q   <= rd_pend_d;
            rd_addr_q   <= rd_addr_d;
        end
    end

    assign rom.rom_addr = addr_q;
    assign rom.rom_din  = din_q;
    assign rom.rom_we   = we_q;
    assign rom.rom_req  = req_q;
    assign cpu_dout     = cpu_dout_q;
    assign cpu_rdy      = rdy_q;
    assign rom_size     = size_q;

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a toggle-handshake SDRAM model of configurable latency.
module tb_rom_load_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic        ioctl_wr;
    logic [21:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        cpu_rd;
    logic [20:0] cpu_addr;
    logic [15:0] cpu_dout;
    logic        cpu_rdy;
    logic [21:0] rom_size;

    rom_load_arbiter_if rom_bus ();

    rom_load_arbiter #(
        .FIFO_DEPTH (4),
        .PAD_BYTE   (8'hFF)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .ioctl_wait     (ioctl_wait),
        .cpu_rd         (cpu_rd),
        .cpu_addr       (cpu_addr),
        .cpu_dout       (cpu_dout),
        .cpu_rdy        (cpu_rdy),
        .rom            (rom_bus.master),
        .rom_size       (rom_size)
    );

    initial forever #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int ack_delay = 0;
    int ack_cyc  = 0;
    int rdy_n    = 0;
    int rdy_cyc  = 0;
    int pushed   = 0;
    logic [15:0] rdy_dat = '0;
    bit busy = 1'b0;

    logic [20:0] log_addr [$];
    logic [15:0] log_din  [$];
    logic        log_we   [$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // SDRAM model: logs each new request, checks it is held, acks after ack_delay cycles.
    initial begin
        int cnt;
        rom_bus.rom_req_ack = 1'b0;
        rom_bus.rom_dout    = '0;
        cnt = 0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                rom_bus.rom_req_ack = 1'b0;
                busy = 1'b0;
            end else begin
                if (!busy && (rom_bus.rom_req !== rom_bus.rom_req_ack)) begin
                    log_addr.push_back(rom_bus.rom_addr);
                    log_din.push_back(rom_bus.rom_din);
                    log_we.push_back(rom_bus.rom_we);
                    busy = 1'b1;
                    cnt  = ack_delay;
                end else if (busy) begin
                    check("req_hold", {rom_bus.rom_addr, rom_bus.rom_din, rom_bus.rom_we,
                                       rom_bus.rom_req},
                          {log_addr[$], log_din[$], log_we[$], ~rom_bus.rom_req_ack});
                end
                if (busy) begin
                    if (cnt == 0) begin
                        rom_bus.rom_dout = (rom_bus.rom_addr == 21'h100) ? 16'hBEEF :
                                           (16'h1234 ^ rom_bus.rom_addr[15:0]);
                        rom_bus.rom_req_ack = rom_bus.rom_req;
                        ack_cyc = cyc;
                        busy = 1'b0;
                    end else begin
                        cnt--;
                    end
                end
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        if (cpu_rdy === 1'b1) begin
            rdy_n++;
            rdy_cyc = cyc;
            rdy_dat = cpu_dout;
        end
    end

    task automatic wr_byte(input logic [21:0] a, input logic [7:0] d);
        int t;
        t = 0;
        while (ioctl_wait && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (t >= 300) check("wait_timeout", 64'(t), 64'(0));
        ioctl_addr = a;
        ioctl_dout = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr   = 1'b0;
        if (a[0]) pushed++;
    endtask

    task automatic wait_log(input int n);
        int t;
        t = 0;
        while ((log_we.size() < n || busy) && t < 600) begin
            @(negedge clk);
            t++;
        end
        check("log_timeout", 64'(log_we.size()), 64'(n));
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_rdy(input int n);
        int t;
        t = 0;
        while (rdy_n < n && t < 600) begin
            @(negedge clk);
            t++;
        end
        check("rdy_timeout", 64'(rdy_n), 64'(n));
        @(negedge clk);
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_din.delete();
        log_we.delete();
    endtask

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        cpu_rd = 1'b0;
        cpu_addr = '0;
        repeat (3) @(negedge clk);

        check("rst_wait", 64'(ioctl_wait), 64'(0));
        check("rst_rdy", 64'(cpu_rdy), 64'(0));
        check("rst_cpu_dout", 64'(cpu_dout), 64'(0));
        check("rst_req", 64'(rom_bus.rom_req), 64'(0));
        check("rst_we", 64'(rom_bus.rom_we), 64'(0));
        check("rst_addr", 64'(rom_bus.rom_addr), 64'(0));
        check("rst_din", 64'(rom_bus.rom_din), 64'(0));
        check("rst_size", 64'(rom_size), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single word write
        ack_delay = 5;
        ioctl_download = 1'b1;
        @(negedge clk);
        wr_byte(22'd0, 8'h11);
        wr_byte(22'd1, 8'h22);
        wait_log(1);
        check("t1_addr", 64'(log_addr[0]), 64'(0));
        check("t1_din", 64'(log_din[0]), 64'h2211);
        check("t1_we", 64'(log_we[0]), 64'(1));
        check("t1_req", 64'(rom_bus.rom_req), 64'(1));
        ioctl_download = 1'b0;
        repeat (6) @(negedge clk);
        check("t1_count", 64'(log_we.size()), 64'(1));
        check("t1_size", 64'(rom_size), 64'(2));

        // Odd-length download with padding
        clear_log();
        ack_delay = 2;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 5; i++) wr_byte(22'(i), 8'hA0 + 8'(i));
        ioctl_download = 1'b0;
        wait_log(3);
        check("t2_a0", 64'(log_addr[0]), 64'(0));
        check("t2_d0", 64'(log_din[0]), 64'hA1A0);
        check("t2_d1", 64'(log_din[1]), 64'hA3A2);
        check("t2_a2", 64'(log_addr[2]), 64'(2));
        check("t2_d2", 64'(log_din[2]), 64'hFFA4);
        check("t2_size", 64'(rom_size), 64'(5));

        // Slow SDRAM, back-to-back bytes, back-pressure
        clear_log();
        pushed = 0;
        ack_delay = 20;
        ioctl_download = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            wr_byte(22'(i), 8'h30 + 8'(i));
            check("t3_wait", 64'(ioctl_wait), 64'((pushed - log_we.size()) >= 3));
        end
        wait_log(4);
        for (int k = 0; k < 4; k++) begin
            check("t3_addr", 64'(log_addr[k]), 64'(k));
            check("t3_din", 64'(log_din[k]), 64'({8'h31 + 8'(2 * k), 8'h30 + 8'(2 * k)}));
        end
        check("t3_overflow", 64'(dut.overflow_q), 64'(0));
        check("t3_wait_end", 64'(ioctl_wait), 64'(0));
        ioctl_download = 1'b0;
        repeat (3) @(negedge clk);
        check("t3_size", 64'(rom_size), 64'(8));

        // CPU read after download
        clear_log();
        ack_delay = 3;
        cpu_addr = 21'h100;
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        wait_rdy(1);
        check("t4_count", 64'(log_we.size()), 64'(1));
        check("t4_we", 64'(log_we[0]), 64'(0));
        check("t4_addr", 64'(log_addr[0]), 64'h100);
        check("t4_rdy_data", 64'(rdy_dat), 64'hBEEF);
        check("t4_latency", 64'(rdy_cyc - ack_cyc), 64'(1));
        repeat (5) @(negedge clk);
        check("t4_pulses", 64'(rdy_n), 64'(1));
        check("t4_cpu_dout", 64'(cpu_dout), 64'hBEEF);

        // CPU read held off by an active download
        clear_log();
        ack_delay = 2;
        ioctl_download = 1'b1;
        @(negedge clk);
        wr_byte(22'd0, 8'h01);
        wr_byte(22'd1, 8'h02);
        cpu_addr = 21'h55;
        cpu_rd = 1'b1;
        @(negedge clk);
        cpu_rd = 1'b0;
        wr_byte(22'd2, 8'h03);
        wr_byte(22'd3, 8'h04);
        repeat (25) @(negedge clk);
        check("t5_held_count", 64'(log_we.size()), 64'(2));
        check("t5_we0", 64'(log_we[0]), 64'(1));
        check("t5_we1", 64'(log_we[1]), 64'(1));
        check("t5_no_rdy", 64'(rdy_n), 64'(1));
        ioctl_download = 1'b0;
        wait_rdy(2);
        check("t5_rd_we", 64'(log_we[2]), 64'(0));
        check("t5_rd_addr", 64'(log_addr[2]), 64'h55);
        check("t5_rd_data", 64'(rdy_dat), 64'h1261);
        check("t5_size", 64'(rom_size), 64'(4));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
